piso_bit_serializer: RTL and testbench
======================================

// Module: piso_bit_serializer
// PURPOSE
//  Parallel-in/serial-out stage feeding the mealy_1010 sequence detector, one bit per clk.
//  Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB- or LSB-first.
//  Back-to-back words stream without gaps. A stall input freezes the shift.
// PARAMETERS
//  WIDTH      8   bits per word; legal range 2..32
//  MSB_FIRST  1   1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//  IDLE_BIT   0   value driven on ser_out when no word is shifting
// PORTS
//  clk         in   1      rising-edge clock; the only clock
//  rst         in   1      reset, synchronous and active-low (rst=0 resets on the next clk edge)
//  load_valid  in   1      load_data is valid
//  load_data   in   WIDTH  word to serialise; sampled on accept
//  load_ready  out  1      block can accept a word this cycle (combinational)
//  en          in   1      shift enable; 0 = stall
//  ser_out     out  1      serial bit to the detector's `in` (registered)
//  ser_valid   out  1      ser_out carries a data bit this cycle (registered)
//  busy        out  1      a word is loaded or shifting (registered)
//  word_done   out  1      1-cycle pulse, coincident with the last bit of a word
// BEHAVIOUR
//  Reset (rst=0 at an edge): state=IDLE, shreg=0, cnt=0, ser_out=IDLE_BIT, ser_valid=0,
//   busy=0, word_done=0. load_ready=0 while rst=0. An in-flight word is discarded, with no partial pulse.
//  FSM has two states, IDLE and SHIFT.
//  Accept = load_valid & load_ready at an edge.
//  IDLE:
//   load_ready=1. On accept, capture load_data and go to SHIFT.
//   On the same edge, drive the first bit on ser_out with ser_valid=1, busy=1, cnt=0.
//   Latency is therefore 1 cycle from accept to the first bit.
//  SHIFT, en=1:
//   Each edge advances one bit and increments cnt.
//   The bit with cnt==WIDTH-1 is the last one; word_done=1 in that cycle.
//  SHIFT, en=0:
//   shreg, cnt, ser_out and busy hold. ser_valid=0 and word_done=0 in the stalled cycle(s).
//   No bit is lost or repeated.
//  load_ready in SHIFT is 1 only when cnt==WIDTH-1 and en=1 (last bit being consumed).
//   An accept here loads the next word, so its first bit follows the previous last bit on the next edge (zero gap).
//  Last bit with no accept: the next edge returns to IDLE.
//   ser_out=IDLE_BIT, ser_valid=0, busy=0.
//  load_valid with load_ready=0 is ignored; the upstream must hold it until accepted.
//   load_data changes while not accepted are harmless.
//  en is don't-care in IDLE; an accept in IDLE is honoured regardless of en.
//  Reset takes priority over accept, en and shift when they coincide.
//  cnt width is clog2(WIDTH). cnt never exceeds WIDTH-1 and wraps to 0 only via a load.
// STRUCTURE
//  serializer_pkg:
//   - state encoding localparams (ST_IDLE=1'b0, ST_SHIFT=1'b1)
//   - clog2 function
//   - default WIDTH constant, shared with the detector bench
//  Sub-module ser_bit_counter: mod-WIDTH counter with clear/enable and a last_o flag
//   (cnt==WIDTH-1). Instantiated once.
//  Shift register, FSM and output registers stay in piso_bit_serializer.
// TESTING
//  Setup: WIDTH=8, MSB_FIRST=1, en=1.
//  1 Single word: rst=0 for 2 cycles, then load 8'hA5 (MSB_FIRST=1).
//    -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive ser_valid cycles.
//    -> word_done high on the 8th bit. Then IDLE with ser_out=0, busy=0.
//    -> Downstream mealy_1010 out pulses once, on the 4th bit.
//  2 Back-to-back: load_valid held with 8'hF0 then 8'h0F.
//    -> 16 contiguous valid bits 11110000_00001111.
//    -> load_ready seen high only in cycle 0 and on bit 8.
//  3 Stall: load 8'h5A, en=0 for 3 cycles after bit 3.
//    -> ser_out holds bit 3 with ser_valid=0.
//    -> Resumes at bit 4. Total of 8 valid bits, sequence 0,1,0,1,1,0,1,0.
//  4 LSB-first: MSB_FIRST=0, load 8'h01.
//    -> bits 1,0,0,0,0,0,0,0.
//  5 Reset mid-word: load 8'hFF, assert rst=0 after bit 4.
//    -> next edge: ser_valid=0, busy=0, no word_done.
//    -> After release, load 8'h00 yields 8 zero bits cleanly.
//  6 Handshake: load_valid=1 while busy mid-word, with load_data changing.
//    -> no accept until the last bit.
//    -> The word accepted is the load_data present at that edge.

Source files
------------

// File: rtl/piso_bit_serializer_pkg.sv
// serializer_pkg: shared constants, FSM state encoding and clog2 helper for the bit serializer
package serializer_pkg;
  localparam int SER_WIDTH = 8;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ser_bit_counter.sv
// ser_bit_counter: mod-WIDTH bit index counter with clear/enable and a last-bit flag
//  clk, rst (sync, active-low) | clr: restart at 0 | inc: advance one bit
//  cnt_o: current bit index | last_o: cnt_o == WIDTH-1
module ser_bit_counter
  import serializer_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int CW = clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
  assign last_o = cnt_q == CW'(WIDTH - 1);
endmodule

// File: rtl/piso_bit_serializer.sv
// piso_bit_serializer: parallel-in/serial-out word serializer with valid/ready load and stall
//  clk, rst (sync, active-low)
//  load_valid/load_data/load_ready: word handshake; load_ready is combinational
//  en: shift enable (0 = stall)
//  ser_out/ser_valid: registered serial bit and its qualifier
//  busy: word in flight | word_done: pulse alongside the last bit of a word
module piso_bit_serializer
  import serializer_pkg::*;
#(
  parameter int   WIDTH = SER_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             word_done
);
  localparam int CW = clog2(WIDTH);
  logic [0:0] state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic ser_out_q, ser_out_d, ser_valid_q, ser_valid_d;
  logic busy_q, busy_d, word_done_q, word_done_d;
  logic accept, advance, last;
  logic [CW-1:0] cnt;
  ser_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk(clk), .rst(rst), .clr(accept), .inc(advance & ~last), .cnt_o(cnt), .last_o(last)
  );
  // In SHIFT a new word can only be taken while the last bit is being consumed
  assign load_ready = rst & ((state_q == ST_IDLE) | (last & en));
  always_comb begin
    accept = load_valid & load_ready;
    advance = (state_q == ST_SHIFT) & en & ~accept;
    state_d = state_q;
    shreg_d = shreg_q;
    ser_out_d = ser_out_q;
    ser_valid_d = 1'b0;
    busy_d = busy_q;
    word_done_d = 1'b0;
    // shreg holds the bits not yet driven, so the head is always at the shift end
    if (accept) begin
      state_d = ST_SHIFT;
      shreg_d = MSB_FIRST ? load_data << 1 : load_data >> 1;
      ser_out_d = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
      ser_valid_d = 1'b1;
      busy_d = 1'b1;
    end else if (advance & last) begin
      state_d = ST_IDLE;
      ser_out_d = IDLE_BIT;
      busy_d = 1'b0;
    end else if (advance) begin
      shreg_d = MSB_FIRST ? shreg_q << 1 : shreg_q >> 1;
      ser_out_d = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
      ser_valid_d = 1'b1;
      word_done_d = cnt == CW'(WIDTH - 2);
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      ser_out_q <= IDLE_BIT;
      ser_valid_q <= 1'b0;
      busy_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      ser_out_q <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      busy_q <= busy_d;
      word_done_q <= word_done_d;
    end
  assign ser_out = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign busy = busy_q;
  assign word_done = word_done_q;
endmodule

// File: tb/tb_piso_bit_serializer.sv
// tb_piso_bit_serializer: directed vector bench for MSB- and LSB-first serializers
module tb_piso_bit_serializer;
  logic clk = 1'b0, rst = 1'b0, load_valid = 1'b0, en = 1'b1;
  logic [7:0] load_data = 8'h00;
  logic rdy_m, so_m, sv_m, busy_m, wd_m;
  logic rdy_l, so_l, sv_l, busy_l, wd_l;
  int checks = 0, errors = 0;
  typedef struct {
    logic r, lv;
    logic [7:0] d;
    logic e, rdy, so, sv, bz, wd;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data), .load_ready(rdy_m),
    .en(en), .ser_out(so_m), .ser_valid(sv_m), .busy(busy_m), .word_done(wd_m)
  );
  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data), .load_ready(rdy_l),
    .en(en), .ser_out(so_l), .ser_valid(sv_l), .busy(busy_l), .word_done(wd_l)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic r, lv, input logic [7:0] d, input logic e, rdy, so, sv, bz, wd);
    vec_t v;
    v.r = r; v.lv = lv; v.d = d; v.e = e; v.rdy = rdy; v.so = so; v.sv = sv; v.bz = bz; v.wd = wd;
    tbl.push_back(v);
  endtask
  task automatic step(input logic r, lv, input logic [7:0] d, input logic e,
                      input logic x_rdy, x_out, x_v, x_b, x_wd, input string tag);
    rst = r; load_valid = lv; load_data = d; en = e;
    #1;
    chk({tag, " load_ready"}, 32'(rdy_m), 32'(x_rdy));
    @(posedge clk);
    #1;
    chk({tag, " ser_out"}, 32'(so_m), 32'(x_out));
    chk({tag, " ser_valid"}, 32'(sv_m), 32'(x_v));
    chk({tag, " busy"}, 32'(busy_m), 32'(x_b));
    chk({tag, " word_done"}, 32'(wd_m), 32'(x_wd));
  endtask
  initial begin
    logic [7:0] w, got;
    int nv;
    // reset, then single word A5
    add(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    add(1, 1, 8'hA5, 1, 1, 1, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0, 0, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0, 1, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0, 0, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0, 0, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0, 1, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0, 0, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0, 1, 1, 1, 1);
    add(1, 0, 8'h00, 1, 1, 0, 0, 0, 0);
    // back-to-back F0 then 0F
    add(1, 1, 8'hF0, 1, 1, 1, 1, 1, 0);
    add(1, 1, 8'h0F, 1, 0, 1, 1, 1, 0);
    add(1, 1, 8'h0F, 1, 0, 1, 1, 1, 0);
    add(1, 1, 8'h0F, 1, 0, 1, 1, 1, 0);
    add(1, 1, 8'h0F, 1, 0, 0, 1, 1, 0);
    add(1, 1, 8'h0F, 1, 0, 0, 1, 1, 0);
    add(1, 1, 8'h0F, 1, 0, 0, 1, 1, 0);
    add(1, 1, 8'h0F, 1, 0, 0, 1, 1, 1);
    add(1, 1, 8'h0F, 1, 1, 0, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0, 0, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0, 0, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0, 0, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0, 1, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0, 1, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0, 1, 1, 1, 0);
    add(1, 0, 8'h00, 1, 0, 1, 1, 1, 1);
    add(1, 0, 8'h00, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].r, tbl[i].lv, tbl[i].d, tbl[i].e, tbl[i].rdy, tbl[i].so, tbl[i].sv,
           tbl[i].bz, tbl[i].wd, $sformatf("vec%0d", i));
    // stall: 5A = 0,1,0,1,1,0,1,0 with en low for 3 cycles after bit 3
    w = 8'h5A;
    got = 8'h00;
    nv = 0;
    step(1, 1, w, 1, 1, 0, 1, 1, 0, "stall load");
    if (sv_m) begin got = {got[6:0], so_m}; nv++; end
    for (int k = 1; k < 8; k++) begin
      step(1, 0, 8'h00, 1, 0, w[7-k], 1, 1, k == 7, $sformatf("stall bit%0d", k));
      if (sv_m) begin got = {got[6:0], so_m}; nv++; end
      if (k == 3)
        for (int s = 0; s < 3; s++) begin
          step(1, 0, 8'h00, 0, 0, 1, 0, 1, 0, $sformatf("stall hold%0d", s));
          if (sv_m) begin got = {got[6:0], so_m}; nv++; end
        end
    end
    chk("stall word", 32'(got), 32'h5A);
    chk("stall valid count", 32'(nv), 32'd8);
    step(1, 0, 8'h00, 1, 1, 0, 0, 0, 0, "stall idle");
    // LSB-first 01 on dut_l: 1,0,0,0,0,0,0,0 (dut_m sees 0,...,0,1)
    w = 8'h01;
    step(1, 1, w, 1, 1, 0, 1, 1, 0, "lsb load");
    chk("lsb bit0", 32'(so_l), 32'd1);
    for (int k = 1; k < 8; k++) begin
      step(1, 0, 8'h00, 1, 0, k == 7, 1, 1, k == 7, $sformatf("lsb msbdut bit%0d", k));
      chk($sformatf("lsb bit%0d", k), 32'(so_l), 32'd0);
      chk($sformatf("lsb valid%0d", k), 32'(sv_l), 32'd1);
      chk($sformatf("lsb done%0d", k), 32'(wd_l), 32'(k == 7));
    end
    step(1, 0, 8'h00, 1, 1, 0, 0, 0, 0, "lsb idle");
    chk("lsb idle busy", 32'(busy_l), 32'd0);
    chk("lsb idle ready", 32'(rdy_l), 32'd1);
    // reset mid-word: FF, rst after bit 4 with load_valid still high
    step(1, 1, 8'hFF, 1, 1, 1, 1, 1, 0, "rstmid load");
    for (int k = 1; k < 5; k++)
      step(1, 0, 8'h00, 1, 0, 1, 1, 1, 0, $sformatf("rstmid bit%0d", k));
    step(0, 1, 8'hFF, 1, 0, 0, 0, 0, 0, "rstmid reset0");
    step(0, 1, 8'hFF, 1, 0, 0, 0, 0, 0, "rstmid reset1");
    step(1, 1, 8'h00, 1, 1, 0, 1, 1, 0, "rstmid zero load");
    for (int k = 1; k < 8; k++)
      step(1, 0, 8'h00, 1, 0, 0, 1, 1, k == 7, $sformatf("rstmid zero bit%0d", k));
    step(1, 0, 8'h00, 1, 1, 0, 0, 0, 0, "rstmid idle");
    // handshake: load_valid held with changing data; only C3 at the last bit is taken
    w = 8'h3C;
    step(1, 1, w, 1, 1, 0, 1, 1, 0, "hs load");
    for (int k = 1; k < 8; k++)
      step(1, 1, 8'(8'h11 * k), 1, 0, w[7-k], 1, 1, k == 7, $sformatf("hs bit%0d", k));
    w = 8'hC3;
    step(1, 1, w, 1, 1, 1, 1, 1, 0, "hs second load");
    for (int k = 1; k < 8; k++)
      step(1, 0, 8'h00, 1, 0, w[7-k], 1, 1, k == 7, $sformatf("hs second bit%0d", k));
    step(1, 0, 8'h00, 1, 1, 0, 0, 0, 0, "hs idle");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
